// File: rtl/sensors_pkg.sv
// Shared types and defaults for the sensor acquisition front-end.
// Used by the scanner, the summer and the benches.
package sensors_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GAP,
      S_DONE
   } scan_state_t;

   localparam int SENSOR_DW      = 8;
   localparam int NR_SENSORS_MAX = 5;
   localparam int TIMEOUT_DEF    = 15;

   localparam logic [SENSOR_DW-1:0] TEMP_MAX_DEF = 8'd125;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sensor_timeout_cnt.sv
// Clearable up-counter; hit_o flags the last cycle a request may be held.
// Width is $clog2(TIMEOUT), never below one bit.
module sensor_timeout_cnt
   import sensors_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hit_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sensors_scanner.sv
// Sequential poller for up to five temperature sensors; frames publish atomically.
// Define SENSORS_RANGE_CHECK_EN to drop samples above TEMP_MAX as absent.
module sensors_scanner
   import sensors_pkg::*;
#(
   parameter int NR_SENSORS = NR_SENSORS_MAX,
   parameter int TIMEOUT    = TIMEOUT_DEF
`ifdef SENSORS_RANGE_CHECK_EN
   ,
   parameter logic [SENSOR_DW-1:0] TEMP_MAX = TEMP_MAX_DEF
`endif
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   output logic [2:0]                    sel_o,
   output logic                          req_o,
   input  logic                          ack_i,
   input  logic [SENSOR_DW-1:0]          data_i,
   output logic [SENSOR_DW*NR_SENSORS-1:0] sensors_data_o,
   output logic [NR_SENSORS-1:0]         sensors_en_o,
   output logic                          valid_o,
   output logic                          busy_o
);

   localparam int         DW   = SENSOR_DW * NR_SENSORS;
   localparam logic [2:0] LAST = 3'(NR_SENSORS - 1);

   scan_state_t state_q, state_d;

   logic [2:0]            sel_q, sel_d;
   logic [DW-1:0]         shd_q, shd_d;
   logic [DW-1:0]         out_q, out_d;
   logic [NR_SENSORS-1:0] she_q, she_d;
   logic [NR_SENSORS-1:0] oen_q, oen_d;

   logic cnt_clr;
   logic cnt_inc;
   logic cnt_hit;
   logic sample_ok;

`ifdef SENSORS_RANGE_CHECK_EN
   assign sample_ok = (data_i <= TEMP_MAX);
`else
   assign sample_ok = 1'b1;
`endif

   sensor_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .hit_o (cnt_hit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         shd_q   <= '0;
         she_q   <= '0;
         out_q   <= '0;
         oen_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         shd_q   <= shd_d;
         she_q   <= she_d;
         out_q   <= out_d;
         oen_q   <= oen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      shd_d   = shd_q;
      she_d   = she_q;
      out_d   = out_q;
      oen_d   = oen_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      req_o   = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               shd_d   = '0;
               she_d   = '0;
               sel_d   = '0;
               cnt_clr = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            req_o = 1'b1;
            // an ack in the timeout cycle still counts as an answer
            if (ack_i) begin
               if (sample_ok) begin
                  shd_d[int'(sel_q)*SENSOR_DW +: SENSOR_DW] = data_i;
                  she_d[sel_q] = 1'b1;
               end
               state_d = S_GAP;
            end else if (cnt_hit) begin
               state_d = S_GAP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_GAP: begin
            cnt_clr = 1'b1;
            if (sel_q == LAST) begin
               out_d   = shd_q;
               oen_d   = she_q;
               state_d = S_DONE;
            end else begin
               sel_d   = sel_q + 3'd1;
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            valid_o = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sel_o          = sel_q;
   assign busy_o         = (state_q != S_IDLE);
   assign sensors_data_o = out_q;
   assign sensors_en_o   = oen_q;

endmodule

// File: tb/tb_sensors_scanner.sv
// Directed bench for sensors_scanner with a behavioural sensor responder
// and a queue of expected frames.
module tb_sensors_scanner;

   localparam int TO = 15;

   typedef struct {
      logic [39:0] d;
      logic [4:0]  e;
      int          cyc;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rst_i   = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  sel_o;
   logic        req_o;
   wire         ack_i;
   wire  [7:0]  data_i;
   logic [39:0] sensors_data_o;
   logic [4:0]  sensors_en_o;
   logic        valid_o;
   logic        busy_o;

   logic        sens_ack  = 1'b0;
   logic [7:0]  sens_data = 8'h00;
   logic        stray_ack = 1'b0;

   int          dly[5];
   logic [7:0]  val[5];
   int          age = 0;

   exp_t        sb[$];
   exp_t        last_e;
   int          errors = 0;
   int          checks = 0;

   assign ack_i  = sens_ack | stray_ack;
   assign data_i = stray_ack ? 8'hEE : sens_data;

   always #5 clk = ~clk;

   sensors_scanner dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .sel_o          (sel_o),
      .req_o          (req_o),
      .ack_i          (ack_i),
      .data_i         (data_i),
      .sensors_data_o (sensors_data_o),
      .sensors_en_o   (sensors_en_o),
      .valid_o        (valid_o),
      .busy_o         (busy_o)
   );

   // sensor k answers after dly[k] cycles of request; negative = silent
   always @(negedge clk) begin
      if (req_o) begin
         if (dly[sel_o] >= 0 && age >= dly[sel_o]) begin
            sens_ack  = 1'b1;
            sens_data = val[sel_o];
         end else begin
            sens_ack  = 1'b0;
            sens_data = 8'h00;
         end
         age++;
      end else begin
         sens_ack  = 1'b0;
         sens_data = 8'h00;
         age       = 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model();
      exp_t e;
      bit   ok;
      int   req;
      e.d   = '0;
      e.e   = '0;
      e.cyc = 1;
      for (int k = 0; k < 5; k++) begin
         ok  = (dly[k] >= 0) && (dly[k] < TO);
         req = ok ? dly[k] + 1 : TO;
`ifdef SENSORS_RANGE_CHECK_EN
         if (val[k] > 8'd125) ok = 1'b0;
`endif
         if (ok) begin
            e.d[8*k +: 8] = val[k];
            e.e[k]        = 1'b1;
         end
         e.cyc += req + 1;
      end
      return e;
   endfunction

   task automatic run_frame(input string tag, input bit hold,
                            input bit stray_gap);
      exp_t e;
      int   cyc;
      bit   seen;
      sb.push_back(model());
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (!hold) start_i = 1'b0;
         stray_ack = stray_gap && busy_o && !req_o && !valid_o;
         if (valid_o) seen = 1'b1;
      end
      stray_ack = 1'b0;
      e = sb.pop_front();
      chk({tag, " valid_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, " valid_cycle"}, 64'(cyc), 64'(e.cyc));
         chk({tag, " data"}, 64'(sensors_data_o), 64'(e.d));
         chk({tag, " en"}, 64'(sensors_en_o), 64'(e.e));
         chk({tag, " busy_done"}, 64'(busy_o), 64'd1);
      end
      last_e = e;
      @(negedge clk);
      chk({tag, " valid_pulse"}, 64'(valid_o), 64'd0);
      chk({tag, " idle_after"}, 64'(busy_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, " no_requeue"}, 64'(busy_o), 64'd0);
   endtask

   task automatic stray_idle(input string tag);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stray_ack = 1'b1;
      end
      @(negedge clk);
      stray_ack = 1'b0;
      chk({tag, " data"}, 64'(sensors_data_o), 64'(last_e.d));
      chk({tag, " en"}, 64'(sensors_en_o), 64'(last_e.e));
      chk({tag, " busy"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int n;
      int pulses;
      dly = '{0, 0, 0, 0, 0};
      val = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      last_e.d = '0;
      last_e.e = '0;
      last_e.cyc = 0;

      repeat (3) @(negedge clk);
      chk("rst sel", 64'(sel_o), 64'd0);
      chk("rst req", 64'(req_o), 64'd0);
      chk("rst data", 64'(sensors_data_o), 64'd0);
      chk("rst en", 64'(sensors_en_o), 64'd0);
      chk("rst valid", 64'(valid_o), 64'd0);
      chk("rst busy", 64'(busy_o), 64'd0);
      rst_i = 1'b0;

      stray_idle("stray0");

      val = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
      run_frame("A", 1'b0, 1'b1);
      chk("A literal data", 64'(sensors_data_o), 64'h32281E140A);
      chk("A literal en", 64'(sensors_en_o), 64'h1F);
      stray_idle("strayA");

      dly = '{0, 0, -1, 0, 0};
      val = '{8'd25, 8'd25, 8'd25, 8'd25, 8'd25};
      run_frame("B", 1'b0, 1'b0);
      chk("B literal en", 64'(sensors_en_o), 64'h1B);

      dly = '{0, TO - 1, 0, 3, 0};
      val = '{8'd200, 8'd7, 8'd8, 8'd9, 8'd10};
      run_frame("C", 1'b1, 1'b0);

      dly = '{0, 0, 0, 0, TO};
      val = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      run_frame("D", 1'b0, 1'b0);

      dly = '{0, 0, 0, -1, 0};
      val = '{8'd60, 8'd61, 8'd62, 8'd63, 8'd64};
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (!(req_o && sel_o == 3'd3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("R reach s3", 64'(req_o && sel_o == 3'd3), 64'd1);
      chk("R hold data", 64'(sensors_data_o), 64'(last_e.d));
      chk("R hold en", 64'(sensors_en_o), 64'(last_e.e));
      rst_i = 1'b1;
      @(negedge clk);
      chk("R sel", 64'(sel_o), 64'd0);
      chk("R req", 64'(req_o), 64'd0);
      chk("R data", 64'(sensors_data_o), 64'd0);
      chk("R en", 64'(sensors_en_o), 64'd0);
      chk("R valid", 64'(valid_o), 64'd0);
      chk("R busy", 64'(busy_o), 64'd0);
      rst_i  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_o || busy_o) pulses++;
      end
      chk("R no_activity", 64'(pulses), 64'd0);

      dly = '{0, 0, 0, 0, 0};
      val = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_frame("E", 1'b0, 1'b0);

      chk("sb empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
